seg_scan_display: RTL and testbench
===================================

# seg_scan_display

Parametrised multiplexed 7-segment display controller for the game board's digit bank (time, score, and future high-score digits). Scans NUM_DIG common-anode digits from the 1 kHz tick and decodes 4-bit values internally. Adds leading-zero suppression, per-digit blink, per-digit decimal point and dwell-based brightness control. Inputs are snapshotted once per frame so mid-frame updates never tear.

## Interface
- NUM_DIG, 4: digits scanned, 1..8.
- DWELL, 2: clk_1k cycles per digit slot, 1..8.
- BLINK_HALF, 250: clk_1k cycles per blink half-period, ≥1.
- DIG_ACTIVE_LOW, 1: 1 means a driven digit's select bit is 0.
- SEG_ACTIVE_LOW, 0: 1 inverts all 8 segment bits at the output.
- Reset rst, asynchronous, active-high; clock clk_1k.
- clk_1k  in  1  scan clock, 1 kHz.
- rst  in  1  async active-high reset.
- digits  in  4*NUM_DIG  value per digit; [3:0] is digit 0, the least significant.
- dp  in  NUM_DIG  decimal point per digit.
- blank_mask  in  NUM_DIG  1 means the digit is forced dark.
- blink_mask  in  NUM_DIG  1 means the digit blinks.
- lz_en  in  1  leading-zero suppression enable.
- bright  in  4  lit cycles per slot; values ≥DWELL give full brightness.
- dig_sel  out  NUM_DIG  digit select, registered.
- seg  out  8  segments {dp,g,f,e,d,c,b,a}, registered.
- frame_start  out  1  one-cycle pulse on each snapshot.

## Operation
- Counters: slot counter cnt (0..DWELL-1) and digit index idx (0..NUM_DIG-1). cnt increments every cycle. When cnt wraps, idx increments. When idx wraps at NUM_DIG-1, a new frame begins.
- Frame start, idx=0 and cnt=0:
  - Snapshot digits, dp, blank_mask, blink_mask, lz_en and bright.
  - Pulse frame_start.
  - All display decisions in the frame use only snapshot values.
- A digit is lit in a cycle only if all of the following hold:
  - cnt < bright_snap;
  - its blank_mask bit is 0;
  - it is not blinked off;
  - it is not wholly suppressed.
- Digit lit: its dig_sel bit is active, all other bits are inactive, and seg carries the decode plus the dp bit.
- No digit lit: dig_sel is all inactive and seg is all off.
- Decode, active-high: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- Leading-zero suppression, when lz_en is set:
  - Scanning from digit NUM_DIG-1 downward, each digit whose value is 0 is suppressed until the first nonzero value.
  - Digit 0 is never suppressed.
  - A suppressed digit with dp set is still driven, showing the dp segment only (seg=80).
  - A suppressed digit with dp clear is wholly suppressed.
- Blink:
  - Free-running counter toggles blink_phase every BLINK_HALF cycles; blink_phase is 0 out of reset.
  - While blink_phase=1, digits with their blink_mask bit set are dark.
- Polarity parameters apply only at the output registers.

## Timing
- Reset values:
  - dig_sel all inactive (all 1s when DIG_ACTIVE_LOW=1).
  - seg all off (00, or FF when SEG_ACTIVE_LOW=1).
  - frame_start 0, blink counter 0, blink_phase 0, snapshot registers cleared.
  - idx=NUM_DIG-1 and cnt=DWELL-1, so the first edge starts a frame.
- First clk_1k edge after rst deasserts:
  - cnt and idx wrap to 0, the snapshot is taken and frame_start=1.
  - dig_sel and seg show digit 0 from the new snapshot in that same cycle. Output logic uses the next-snapshot values.
- Frame length is NUM_DIG*DWELL cycles; frame_start repeats at that period.
- Input change latency: visible at the next frame_start, at most NUM_DIG*DWELL cycles later.
- dig_sel and seg change on the same edge; there is no cycle with a new select and old segments.
- Blink phase is independent of frame alignment. A phase change mid-frame takes effect on the next edge.
- rst asserted mid-frame: outputs go to reset values immediately (asynchronously). On release, behaviour is identical to power-up.

## Structure
- Shared package seg_pkg: segment bit-order constants, the 16-entry active-high decode table, and the polarity helper.
- One combinational sub-module, seg7_hex_lut: 4-bit value to 7-bit segments.
- Top level holds the counters, snapshot registers, LZ chain, blink generator and output registers.

## Test plan
All scenarios use NUM_DIG=4, DWELL=2, active-low digits, active-high segments unless stated.
- Reset: hold rst → dig_sel=1111, seg=00, frame_start=0. Release → the first edge gives frame_start=1 and dig_sel=1110.
- digits=1234, bright=2, lz_en=0 → dig_sel sequence 1110,1110,1101,1101,1011,1011,0111,0111 with seg 66,66,4F,4F,5B,5B,06,06.
- lz_en=1, digits=0070 → digits 3 and 2 dark, digit 1 shows 07, digit 0 shows 3F.
  - digits=0000 → only digit 0 shows 3F.
  - digits=0000 with dp=0100 → digit 2 shows 80.
- Brightness: bright=1 → each digit active only in slot cycle 0, dark in cycle 1. bright=0 → dig_sel stays 1111 for the whole frame.
- Blink with BLINK_HALF=8, blink_mask=0001, digits=0005 → digit 0 shows 6D for 8 cycles, then is dark for 8 cycles, repeating. Other digits are unaffected.
- Snapshot integrity: change digits from 1234 to 5678 while idx=2.
  - Digits 2 and 3 still show 2 and 1 in that frame.
  - The next frame shows 8, 7, 6, 5.
  - rst pulsed mid-frame → outputs go to reset values within the same cycle.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed 7-segment display controller:
// segment bit positions, the active-high hex decode table and the
// output polarity helper.
package seg_pkg;

    // Segment bit positions inside the 8-bit {dp,g,f,e,d,c,b,a} bus
    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Active-high segment patterns
    localparam logic [7:0] SEG_ALL_OFF = 8'h00;
    localparam logic [7:0] SEG_DP_ONLY = 8'h80;

    // Active-high {g,f,e,d,c,b,a} patterns for 0..F (b and d in lower case)
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Convert an active-high segment word to the board's pin polarity
    function automatic logic [7:0] seg_polarity(input logic [7:0] v, input logic inv);
        return inv ? ~v : v;
    endfunction

endpackage

// File: rtl/seg7_hex_lut.sv
// Combinational hex-to-7-segment decoder (active-high, {g,f,e,d,c,b,a}).
module seg7_hex_lut
    import seg_pkg::*;
(
    input  logic [3:0] val,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[val];

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed common-anode 7-segment scanner. Walks NUM_DIG digits with
// DWELL clk_1k cycles per digit, snapshots all display inputs once per
// frame, and applies leading-zero suppression, blink, decimal point and
// dwell-based brightness. Outputs are registered and always consistent.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int NUM_DIG        = 4,
    parameter int DWELL          = 2,
    parameter int BLINK_HALF     = 250,
    parameter int DIG_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                   clk_1k,
    input  logic                   rst,
    input  logic [4*NUM_DIG-1:0]   digits,
    input  logic [NUM_DIG-1:0]     dp,
    input  logic [NUM_DIG-1:0]     blank_mask,
    input  logic [NUM_DIG-1:0]     blink_mask,
    input  logic                   lz_en,
    input  logic [3:0]             bright,
    output logic [NUM_DIG-1:0]     dig_sel,
    output logic [7:0]             seg,
    output logic                   frame_start
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int IDX_W = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam int BLK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIG - 1);
    localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_HALF - 1);

    localparam logic [NUM_DIG-1:0] DIG_IDLE = (DIG_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [7:0]         SEG_IDLE = seg_polarity(SEG_ALL_OFF, SEG_ACTIVE_LOW != 0);

    // Scan position
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             frame_d;

    // Blink generator
    logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_phase_q, blink_phase_d;

    // Per-frame snapshot of the display inputs
    logic [4*NUM_DIG-1:0] digits_snap_q, digits_snap_d;
    logic [NUM_DIG-1:0]   dp_snap_q, dp_snap_d;
    logic [NUM_DIG-1:0]   blank_snap_q, blank_snap_d;
    logic [NUM_DIG-1:0]   blink_snap_q, blink_snap_d;
    logic                 lz_snap_q, lz_snap_d;
    logic [3:0]           bright_snap_q, bright_snap_d;

    // Output registers
    logic [NUM_DIG-1:0] dig_sel_q, dig_sel_d;
    logic [7:0]         seg_q, seg_d;
    logic               frame_start_q;

    // Current-digit decode inputs
    logic [NUM_DIG-1:0] supp;
    logic [3:0]         cur_val;
    logic               cur_dp, cur_blank, cur_blink, cur_supp;
    logic [6:0]         lut_seg;
    logic               lit;
    logic [7:0]         seg_raw;

    seg7_hex_lut u_hex_lut (
        .val (cur_val),
        .seg (lut_seg)
    );

    // Slot/digit counters and blink counter advance; frame begins on double wrap
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
        end
        frame_d = (cnt_d == '0) && (idx_d == '0);

        blink_cnt_d   = (blink_cnt_q == BLK_MAX) ? '0 : blink_cnt_q + BLK_W'(1);
        blink_phase_d = blink_phase_q ^ (blink_cnt_q == BLK_MAX);
    end

    // Snapshot capture and next-cycle output decision (uses next-snapshot values
    // so the first slot of a frame already reflects the new snapshot)
    always_comb begin
        logic run;

        digits_snap_d = frame_d ? digits     : digits_snap_q;
        dp_snap_d     = frame_d ? dp         : dp_snap_q;
        blank_snap_d  = frame_d ? blank_mask : blank_snap_q;
        blink_snap_d  = frame_d ? blink_mask : blink_snap_q;
        lz_snap_d     = frame_d ? lz_en      : lz_snap_q;
        bright_snap_d = frame_d ? bright     : bright_snap_q;

        // Leading-zero chain from the most significant digit down; digit 0 never blanks
        run = lz_snap_d;
        for (int i = NUM_DIG - 1; i >= 0; i--) begin
            run     = run && (digits_snap_d[4*i +: 4] == 4'h0);
            supp[i] = run && (i != 0);
        end

        cur_val   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_blink = 1'b0;
        cur_supp  = 1'b0;
        for (int i = 0; i < NUM_DIG; i++) begin
            if (idx_d == IDX_W'(i)) begin
                cur_val   = digits_snap_d[4*i +: 4];
                cur_dp    = dp_snap_d[i];
                cur_blank = blank_snap_d[i];
                cur_blink = blink_snap_d[i];
                cur_supp  = supp[i];
            end
        end

        lit = (32'(cnt_d) < 32'(bright_snap_d))
              && !cur_blank
              && !(blink_phase_q && cur_blink)
              && !(cur_supp && !cur_dp);

        seg_raw = cur_supp ? SEG_DP_ONLY : {cur_dp, lut_seg};

        dig_sel_d = DIG_IDLE;
        seg_d     = SEG_IDLE;
        if (lit) begin
            dig_sel_d = (NUM_DIG'(1) << idx_d) ^ DIG_IDLE;
            seg_d     = seg_polarity(seg_raw, SEG_ACTIVE_LOW != 0);
        end
    end

    // State, snapshot and output registers with asynchronous reset
    always_ff @(posedge clk_1k or posedge rst) begin
        if (rst) begin
            cnt_q         <= CNT_MAX;
            idx_q         <= IDX_MAX;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            digits_snap_q <= '0;
            dp_snap_q     <= '0;
            blank_snap_q  <= '0;
            blink_snap_q  <= '0;
            lz_snap_q     <= 1'b0;
            bright_snap_q <= '0;
            dig_sel_q     <= DIG_IDLE;
            seg_q         <= SEG_IDLE;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            digits_snap_q <= digits_snap_d;
            dp_snap_q     <= dp_snap_d;
            blank_snap_q  <= blank_snap_d;
            blink_snap_q  <= blink_snap_d;
            lz_snap_q     <= lz_snap_d;
            bright_snap_q <= bright_snap_d;
            dig_sel_q     <= dig_sel_d;
            seg_q         <= seg_d;
            frame_start_q <= frame_d;
        end
    end

    assign dig_sel     = dig_sel_q;
    assign seg         = seg_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display (4 digits, dwell 2, blink half-period 8,
// active-low digit selects, active-high segments).
module tb_seg_scan_display;

    localparam int ND = 4;
    localparam int DW = 2;
    localparam int BH = 8;
    localparam int FRAME = ND * DW;

    logic          clk_1k = 1'b0;
    logic          rst;
    logic [15:0]   digits;
    logic [3:0]    dp, blank_mask, blink_mask;
    logic          lz_en;
    logic [3:0]    bright;
    logic [3:0]    dig_sel;
    logic [7:0]    seg;
    logic          frame_start;

    int total = 0;
    int bad   = 0;

    seg_scan_display #(
        .NUM_DIG(ND), .DWELL(DW), .BLINK_HALF(BH),
        .DIG_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(0)
    ) dut (
        .clk_1k      (clk_1k),
        .rst         (rst),
        .digits      (digits),
        .dp          (dp),
        .blank_mask  (blank_mask),
        .blink_mask  (blink_mask),
        .lz_en       (lz_en),
        .bright      (bright),
        .dig_sel     (dig_sel),
        .seg         (seg),
        .frame_start (frame_start)
    );

    always #5 clk_1k = ~clk_1k;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] hex_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    int         n = 0;
    logic [15:0] s_dig;
    logic [3:0]  s_dp, s_blank, s_blink, s_br;
    logic        s_lz;

    always @(posedge clk_1k) begin
        int c, d;
        bit ph, fs, lead0, lit;
        logic [3:0] e_sel;
        logic [7:0] e_seg;
        if (rst) begin
            n = 0;
            #1;
            chk("m_rst_sel", {4'h0, dig_sel}, 8'h0F);
            chk("m_rst_seg", seg, 8'h00);
            chk("m_rst_fs", {7'h0, frame_start}, 8'h00);
        end else begin
            fs = (n % FRAME == 0);
            if (fs) begin
                s_dig = digits; s_dp = dp; s_blank = blank_mask;
                s_blink = blink_mask; s_lz = lz_en; s_br = bright;
            end
            c  = n % DW;
            d  = (n / DW) % ND;
            ph = ((n / BH) % 2) == 1;
            n++;
            // digit d is a leading zero if it and every higher digit are zero
            lead0 = 1'b1;
            for (int j = d; j < ND; j++)
                if (s_dig[4*j +: 4] != 4'h0) lead0 = 1'b0;
            lead0 = lead0 && s_lz && (d != 0);
            lit = (c < int'(s_br)) && !s_blank[d] && !(ph && s_blink[d]) && !(lead0 && !s_dp[d]);
            e_sel = 4'hF;
            e_seg = 8'h00;
            if (lit) begin
                e_sel = ~(4'b0001 << d);
                e_seg = lead0 ? 8'h80 : (hex_tab[s_dig[4*d +: 4]] | {s_dp[d], 7'h0});
            end
            #1;
            chk("m_sel", {4'h0, dig_sel}, {4'h0, e_sel});
            chk("m_seg", seg, e_seg);
            chk("m_fs", {7'h0, frame_start}, {7'h0, fs});
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_frame();
        int k = 0;
        do begin
            @(negedge clk_1k);
            k++;
        end while (!frame_start && k < 4 * FRAME);
        chk("frame_wait", {7'h0, frame_start}, 8'h01);
    endtask

    // Assumes the current negedge is the first slot of a frame
    task automatic check_frame(input string nm, input logic [31:0] es, input logic [63:0] eg);
        for (int i = 0; i < FRAME; i++) begin
            if (i > 0) @(negedge clk_1k);
            chk({nm, "_sel"}, {4'h0, dig_sel}, {4'h0, es[(7-i)*4 +: 4]});
            chk({nm, "_seg"}, seg, eg[(7-i)*8 +: 8]);
        end
    endtask

    task automatic set_in(input logic [15:0] dg, input logic [3:0] p, input logic [3:0] bl,
                          input logic [3:0] bk, input logic lz, input logic [3:0] br);
        digits = dg; dp = p; blank_mask = bl; blink_mask = bk; lz_en = lz; bright = br;
    endtask

    initial begin
        int cnt0, cnt3;
        rst = 1'b1;
        set_in(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0, 4'd2);
        repeat (3) @(negedge clk_1k);
        chk("rst_sel", {4'h0, dig_sel}, 8'h0F);
        chk("rst_seg", seg, 8'h00);
        chk("rst_fs", {7'h0, frame_start}, 8'h00);
        rst = 1'b0;

        @(negedge clk_1k);
        chk("first_fs", {7'h0, frame_start}, 8'h01);
        check_frame("d1234", 32'hEEDDBB77, 64'h66664F4F5B5B0606);

        set_in(16'h0070, 4'h0, 4'h0, 4'h0, 1'b1, 4'd2);
        wait_frame();
        check_frame("lz0070", 32'hEEDDFFFF, 64'h3F3F070700000000);

        set_in(16'h0000, 4'h0, 4'h0, 4'h0, 1'b1, 4'd2);
        wait_frame();
        check_frame("lz0000", 32'hEEFFFFFF, 64'h3F3F000000000000);

        set_in(16'h0000, 4'b0100, 4'h0, 4'h0, 1'b1, 4'd2);
        wait_frame();
        check_frame("lzdp", 32'hEEFFBBFF, 64'h3F3F000080800000);

        set_in(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0, 4'd1);
        wait_frame();
        check_frame("br1", 32'hEFDFBF7F, 64'h66004F005B000600);

        set_in(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0, 4'd0);
        wait_frame();
        check_frame("br0", 32'hFFFFFFFF, 64'h0000000000000000);

        // Snapshot integrity: inputs change while digit 2 is being scanned
        set_in(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0, 4'd2);
        wait_frame();
        for (int i = 0; i < FRAME; i++) begin
            if (i > 0) @(negedge clk_1k);
            chk("snap_old_sel", {4'h0, dig_sel}, {4'h0, 32'hEEDDBB77 >> ((7-i)*4)} & 8'h0F);
            chk("snap_old_seg", seg, 8'((64'h66664F4F5B5B0606 >> ((7-i)*8)) & 64'hFF));
            if (i == 4) digits = 16'h5678;
        end
        @(negedge clk_1k);
        chk("snap_new_fs", {7'h0, frame_start}, 8'h01);
        check_frame("snap_new", 32'hEEDDBB77, 64'h7F7F07077D7D6D6D);

        // Asynchronous reset mid-frame
        repeat (3) @(negedge clk_1k);
        #2 rst = 1'b1;
        #1;
        chk("arst_sel", {4'h0, dig_sel}, 8'h0F);
        chk("arst_seg", seg, 8'h00);
        chk("arst_fs", {7'h0, frame_start}, 8'h00);
        @(negedge clk_1k);
        rst = 1'b0;
        @(negedge clk_1k);
        chk("rel_fs", {7'h0, frame_start}, 8'h01);
        chk("rel_sel", {4'h0, dig_sel}, 8'h0E);
        chk("rel_seg", seg, 8'h7F);

        // Blink: frames align with blink half-periods, so digit 0 is lit in
        // every other frame (2 cycles each) while digit 3 never blinks
        set_in(16'h0005, 4'h0, 4'h0, 4'b0001, 1'b0, 4'd2);
        wait_frame();
        cnt0 = 0;
        cnt3 = 0;
        for (int i = 0; i < 8 * FRAME; i++) begin
            if (i > 0) @(negedge clk_1k);
            if (dig_sel == 4'hE && seg == 8'h6D) cnt0++;
            if (dig_sel == 4'h7 && seg == 8'h3F) cnt3++;
        end
        chk("blink_d0_cnt", 8'(cnt0), 8'd8);
        chk("blink_d3_cnt", 8'(cnt3), 8'd16);

        // Randomized traffic, checked by the model every cycle
        for (int i = 0; i < 600; i++) begin
            @(negedge clk_1k);
            if ($urandom_range(0, 3) == 0) begin
                logic [15:0] dg;
                for (int j = 0; j < 4; j++)
                    dg[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
                set_in(dg, 4'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0),
                       4'($urandom), 1'($urandom), 4'($urandom_range(0, 15) < 12 ? $urandom_range(0, 3)
                                                                               : $urandom_range(0, 15)));
            end
        end
        @(negedge clk_1k);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
